cqf_cycle_ctrl: RTL and testbench
=================================

CQF_CYCLE_CTRL -- requirements
Module: cqf_cycle_ctrl

Interface
REQ-001 SHALL have parameter CYCLE_LEN, default 2048, clocks per CQF cycle (slot).
REQ-002 SHALL have parameter GUARD_LEN, default 64, guard-band clocks at the end of each cycle (< CYCLE_LEN).
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_vld_i/in_eop_i/in_data_i  in  1/1/DW  and in_rdy_o  out  1: upstream frame beats.
REQ-007 SHALL have ports fifo_sel_o/cq_vld_o/cq_eop_o/cq_data_o  out  1/1/1/DW  and cq_rdy_i  in  1: queue-manager enqueue side.
REQ-008 SHALL have ports cq_req_o  out  1, cq_ack_i  in  1, cq_data_i  in  DW, cq_status_i  in  2: queue-manager dequeue side; status[0] = drain queue empty, status[1] = enqueue queue full.
REQ-009 SHALL have ports out_vld_o/out_data_o  out  1/DW  and out_rdy_i  in  1: egress stream.
REQ-010 SHALL have ports boundary_o  out  1 (cycle-end pulse), overrun_o  out  1, drain_late_o  out  1 (sticky flags).

Function
REQ-011 cycle_cnt SHALL count 0..CYCLE_LEN-1, wrap to 0; boundary_o high for exactly the clock in which cycle_cnt == CYCLE_LEN-1.
REQ-012 Ingress FSM SHALL have states IDLE, PASS, HOLD.
REQ-013 IDLE: in_vld_i high, in guard window (cycle_cnt >= CYCLE_LEN-GUARD_LEN) or cq_status_i[1] high -> HOLD, in_rdy_o low; otherwise -> PASS.
REQ-014 HOLD: in_rdy_o low; -> PASS on the first clock that is outside the guard window with cq_status_i[1] low.
REQ-015 PASS: cq_vld_o = in_vld_i, in_rdy_o = cq_rdy_i, data/eop combinational pass-through; beat accepted when in_vld_i & cq_rdy_i; return to IDLE on accepted eop beat.
REQ-016 fifo_sel_o SHALL toggle on boundary when ingress is IDLE or HOLD; if in PASS, toggle deferred to the clock after eop acceptance and overrun_o set.
REQ-017 fifo_sel_o SHALL never change while ingress is in PASS (no frame straddles two queues).
REQ-018 Drain queue SHALL be ~fifo_sel_o; draining enabled from each fifo_sel_o toggle until cq_status_i[0] high.
REQ-019 cq_ack_i qualifies cq_data_i one clock after cq_req_o; the block SHALL hold a 2-entry skid buffer and assert cq_req_o only when drain enabled, status[0] low and (skid occupancy + in-flight) < 2.
REQ-020 out_vld_o SHALL be high while skid non-empty; entry popped when out_vld_o & out_rdy_i; order preserved; no beat lost or duplicated.
REQ-021 drain_late_o SHALL set if cq_status_i[0] is low at a fifo_sel_o toggle; draining then switches to the new drain queue.
REQ-022 Simultaneous skid push and pop SHALL keep occupancy unchanged.

Reset
REQ-023 On rst_i: cycle_cnt=0, ingress IDLE, fifo_sel_o=0, drain disabled, skid empty.
REQ-024 Reset outputs: in_rdy_o=0, cq_vld_o=0, cq_eop_o=0, cq_req_o=0, out_vld_o=0, boundary_o=0, overrun_o=0, drain_late_o=0; data outputs 0.
REQ-025 Reset mid-frame SHALL discard the in-flight frame and skid contents; no beat emitted in the clock after reset deasserts.

Configuration
REQ-026 Macro CQF_GUARD_EN: defined -> guard-window hold of REQ-013/014 active; undefined -> guard window ignored (HOLD only on queue full), straddling frames handled solely by REQ-016 deferral.

Verification
REQ-027 Reset released, no traffic -> boundary_o pulses at cnt 2047, 4095; fifo_sel_o 0->1->0.
REQ-028 1024-beat frame starting cnt 10, cq_rdy_i=1 -> all beats on cq_* with fifo_sel_o=0, eop at cnt 1033, overrun_o=0.
REQ-029 Frame start at cnt 2000 (GUARD_EN) -> in_rdy_o low until fifo_sel_o=1, frame enqueued into queue 1; without macro -> enqueued into queue 0 if it completes before 2047, else overrun_o=1.
REQ-030 Queue 0 holds 16 beats, toggle to sel=1, out_rdy_i toggling 50% -> 16 beats out in order, cq_req_o stops at status[0]=1.
REQ-031 Drain queue still non-empty at next boundary -> drain_late_o=1, persistent until reset.
REQ-032 rst_i pulsed mid-PASS at cnt 500 -> all outputs at reset values next clock, fifo_sel_o=0.

Source files
------------

// File: rtl/cqf_cycle_ctrl.sv
// CQF cycle controller: slot counter, ingress gating, queue select and drain skid buffer.
// Optional guard-window hold is enabled by defining CQF_GUARD_EN.
module cqf_cycle_ctrl #(
    parameter int CYCLE_LEN = 2048,
    parameter int GUARD_LEN = 64,
    parameter int DW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_vld_i,
    input  logic          in_eop_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_rdy_o,
    output logic          fifo_sel_o,
    output logic          cq_vld_o,
    output logic          cq_eop_o,
    output logic [DW-1:0] cq_data_o,
    input  logic          cq_rdy_i,
    output logic          cq_req_o,
    input  logic          cq_ack_i,
    input  logic [DW-1:0] cq_data_i,
    input  logic [1:0]    cq_status_i,
    output logic          out_vld_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_rdy_i,
    output logic          boundary_o,
    output logic          overrun_o,
    output logic          drain_late_o
);

    localparam int CW = $clog2(CYCLE_LEN);
    localparam logic [CW-1:0] CNT_LAST    = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] GUARD_START = CW'(CYCLE_LEN - GUARD_LEN);

`ifdef CQF_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic          pend_q, pend_d;
    logic          overrun_q, overrun_d;
    logic          late_q, late_d;
    logic          drain_q, drain_d;
    logic          req_q, req_d;
    logic [DW-1:0] skid_q [2];
    logic [DW-1:0] skid_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;

    logic boundary, guard_win, hold_cond, pass;
    logic eop_acc, sel_due, toggle, push, pop;

    assign boundary  = (cnt_q == CNT_LAST);
    assign guard_win = GUARD_EN & (cnt_q >= GUARD_START);
    assign hold_cond = guard_win | cq_status_i[1];
    assign pass      = (state_q == ST_PASS);
    assign eop_acc   = pass & in_vld_i & cq_rdy_i & in_eop_i;

    assign in_rdy_o  = pass & cq_rdy_i;
    assign cq_vld_o  = pass & in_vld_i;
    assign cq_eop_o  = pass & in_eop_i;
    assign cq_data_o = pass ? in_data_i : '0;

    // A boundary hit mid-frame is remembered and applied once the frame ends
    assign sel_due = boundary | pend_q;
    assign toggle  = sel_due & (~pass | eop_acc);

    assign push      = req_q & cq_ack_i;
    assign out_vld_o = (occ_q != 2'd0);
    assign pop       = out_vld_o & out_rdy_i;
    assign cq_req_o  = drain_q & ~cq_status_i[0]
                     & ((occ_q + {1'b0, req_q}) < 2'd2);

    assign out_data_o   = out_vld_o ? skid_q[rd_ptr_q] : '0;
    assign fifo_sel_o   = sel_q;
    assign boundary_o   = boundary;
    assign overrun_o    = overrun_q;
    assign drain_late_o = late_q;

    always_comb begin
        cnt_d   = boundary ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_vld_i) state_d = hold_cond ? ST_HOLD : ST_PASS;
            ST_HOLD: if (!hold_cond) state_d = ST_PASS;
            ST_PASS: if (eop_acc) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d     = sel_q ^ toggle;
        pend_d    = sel_due & ~toggle;
        overrun_d = overrun_q | (boundary & pass & ~eop_acc);
        late_d    = late_q | (toggle & ~cq_status_i[0]);
        drain_d   = toggle | (drain_q & ~cq_status_i[0]);
        req_d     = cq_req_o;
    end

    always_comb begin
        skid_d   = skid_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        if (push) skid_d[wr_ptr_q] = cq_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            late_q    <= 1'b0;
            drain_q   <= 1'b0;
            req_q     <= 1'b0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            late_q    <= late_d;
            drain_q   <= drain_d;
            req_q     <= req_d;
            skid_q    <= skid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
        end
    end

endmodule

// File: tb/tb_cqf_cycle_ctrl.sv
// Directed bench for cqf_cycle_ctrl with a small behavioural queue manager.
// Expectations follow CQF_GUARD_EN when the bench is built with it.
module tb_cqf_cycle_ctrl;

    localparam int DW = 8;
    localparam int CL = 2048;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_vld_i = 1'b0;
    logic          in_eop_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_rdy_o;
    logic          fifo_sel_o;
    logic          cq_vld_o;
    logic          cq_eop_o;
    logic [DW-1:0] cq_data_o;
    logic          cq_rdy_i = 1'b1;
    logic          cq_req_o;
    logic          cq_ack_i;
    logic [DW-1:0] cq_data_i;
    logic [1:0]    cq_status_i;
    logic          out_vld_o;
    logic [DW-1:0] out_data_o;
    logic          out_rdy_i = 1'b1;
    logic          boundary_o;
    logic          overrun_o;
    logic          drain_late_o;

    logic full_f = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   tcnt = 0;

    always #5 clk = ~clk;

    cqf_cycle_ctrl #(.CYCLE_LEN(CL), .GUARD_LEN(64), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_vld_i(in_vld_i), .in_eop_i(in_eop_i), .in_data_i(in_data_i),
        .in_rdy_o(in_rdy_o), .fifo_sel_o(fifo_sel_o),
        .cq_vld_o(cq_vld_o), .cq_eop_o(cq_eop_o), .cq_data_o(cq_data_o),
        .cq_rdy_i(cq_rdy_i), .cq_req_o(cq_req_o), .cq_ack_i(cq_ack_i),
        .cq_data_i(cq_data_i), .cq_status_i(cq_status_i),
        .out_vld_o(out_vld_o), .out_data_o(out_data_o), .out_rdy_i(out_rdy_i),
        .boundary_o(boundary_o), .overrun_o(overrun_o),
        .drain_late_o(drain_late_o)
    );

    // Reference slot counter
    always @(posedge clk) tcnt <= rst_i ? 0 : ((tcnt == CL - 1) ? 0 : tcnt + 1);

    // Queue manager model: two queues, dequeue ack one clock after request
    logic [DW-1:0] qm_mem [2][0:2047];
    int   qm_wr [2];
    int   qm_rd [2];
    int   eop_cnt;
    logic dq;
    logic qm_empty;
    assign dq = ~fifo_sel_o;
    assign qm_empty = (qm_wr[dq] == qm_rd[dq]);
    assign cq_status_i = {full_f, qm_empty};

    always @(posedge clk) begin
        if (rst_i) begin
            qm_wr[0] <= 0; qm_wr[1] <= 0;
            qm_rd[0] <= 0; qm_rd[1] <= 0;
            cq_ack_i <= 1'b0; cq_data_i <= '0;
            eop_cnt <= -1;
        end else begin
            cq_ack_i <= 1'b0;
            if (cq_req_o && !qm_empty) begin
                cq_ack_i <= 1'b1;
                cq_data_i <= qm_mem[dq][qm_rd[dq] % 2048];
                qm_rd[dq] <= qm_rd[dq] + 1;
            end
            if (cq_vld_o && cq_rdy_i) begin
                qm_mem[fifo_sel_o][qm_wr[fifo_sel_o] % 2048] <= cq_data_o;
                qm_wr[fifo_sel_o] <= qm_wr[fifo_sel_o] + 1;
                if (cq_eop_o) eop_cnt <= tcnt;
            end
        end
    end

    typedef struct {
        logic vld; logic eop; logic [7:0] d; logic rdy; logic full;
        logic e_vld; logic e_rdy; logic e_eop; logic [7:0] e_d;
    } vec_t;
    vec_t vt [14];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int n);
        int g = 0;
        while (tcnt != n && g < 5000) begin
            step();
            g++;
        end
        chk("goto", tcnt, n);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        in_vld_i = 1'b0;
        in_eop_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic send_frame(int n, logic [7:0] base);
        int i = 0;
        int g = 0;
        logic acc;
        in_vld_i = 1'b1;
        in_data_i = base;
        in_eop_i = (n == 1);
        while (i < n && g < 5000) begin
            @(negedge clk);
            acc = in_rdy_o;
            step();
            g++;
            if (acc) begin
                i++;
                in_data_i = base + 8'(i);
                in_eop_i = (i == n - 1);
            end
        end
        in_vld_i = 1'b0;
        in_eop_i = 1'b0;
        chk("frame_done", i, n);
    endtask

    task automatic chk_reset_outs(string name);
        chk(name, {in_rdy_o, cq_vld_o, cq_eop_o, cq_data_o, cq_req_o,
                   out_vld_o, out_data_o, boundary_o, overrun_o,
                   drain_late_o, fifo_sel_o}, 64'd0);
    endtask

    logic [7:0] got [$];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1};
        vt[2]  = '{1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2};
        vt[3]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vt[4]  = '{1'b1, 1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC4};
        vt[5]  = '{1'b1, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC4};
        vt[6]  = '{1'b1, 1'b0, 8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[7]  = '{1'b1, 1'b1, 8'hE6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hE6};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[9]  = '{1'b1, 1'b0, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[10] = '{1'b1, 1'b0, 8'hF7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[11] = '{1'b1, 1'b0, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[12] = '{1'b1, 1'b1, 8'hF7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF7};
        vt[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state
        step();
        step();
        @(negedge clk);
        chk_reset_outs("reset_hold");
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset_release");

        // Idle slot boundaries
        goto(2046);
        @(negedge clk); chk("bnd_pre", boundary_o, 1'b0);
        step();
        @(negedge clk); chk("bnd_2047", boundary_o, 1'b1);
        chk("sel_before", fifo_sel_o, 1'b0);
        step();
        @(negedge clk); chk("bnd_wrap", boundary_o, 1'b0);
        chk("sel_first", fifo_sel_o, 1'b1);
        goto(2047);
        @(negedge clk); chk("bnd_4095", boundary_o, 1'b1);
        step();
        @(negedge clk); chk("sel_second", fifo_sel_o, 1'b0);
        chk("idle_flags", {overrun_o, drain_late_o, cq_req_o}, 3'b000);

        // Ingress handshake vectors
        do_reset();
        goto(5);
        for (int i = 0; i < 14; i++) begin
            in_vld_i = vt[i].vld;
            in_eop_i = vt[i].eop;
            in_data_i = vt[i].d;
            cq_rdy_i = vt[i].rdy;
            full_f = vt[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {cq_vld_o, in_rdy_o, cq_eop_o, cq_data_o},
                {vt[i].e_vld, vt[i].e_rdy, vt[i].e_eop, vt[i].e_d});
            step();
        end
        in_vld_i = 1'b0; in_eop_i = 1'b0; cq_rdy_i = 1'b1; full_f = 1'b0;

        // 1024-beat frame, first beat at cnt 10
        do_reset();
        goto(9);
        send_frame(1024, 8'h00);
        chk("long_eop_cnt", eop_cnt, 1033);
        chk("long_q0", qm_wr[0], 1024);
        chk("long_q1", qm_wr[1], 0);
        chk("long_sel", fifo_sel_o, 1'b0);
        chk("long_ovr", overrun_o, 1'b0);
        chk("long_last", qm_mem[0][1023], 8'hFF);

        // Short frame inside guard window
        do_reset();
        goto(2000);
        send_frame(10, 8'h80);
`ifdef CQF_GUARD_EN
        chk("guard_q1", qm_wr[1], 10);
        chk("guard_q0", qm_wr[0], 0);
        chk("guard_eop", eop_cnt, 10);
        chk("guard_sel", fifo_sel_o, 1'b1);
`else
        chk("guard_q0", qm_wr[0], 10);
        chk("guard_q1", qm_wr[1], 0);
        chk("guard_eop", eop_cnt, 2010);
        chk("guard_sel", fifo_sel_o, 1'b0);
`endif
        chk("guard_ovr", overrun_o, 1'b0);

        // Frame straddling the boundary
        do_reset();
        goto(2000);
        send_frame(100, 8'h00);
`ifdef CQF_GUARD_EN
        chk("strad_q", qm_wr[1], 100);
        chk("strad_ovr", overrun_o, 1'b0);
        chk("strad_eop", eop_cnt, 100);
`else
        chk("strad_q", qm_wr[0], 100);
        chk("strad_ovr", overrun_o, 1'b1);
        chk("strad_eop", eop_cnt, 52);
`endif
        chk("strad_sel", fifo_sel_o, 1'b1);

        // Drain 16 beats with 50% egress ready
        do_reset();
        goto(100);
        send_frame(16, 8'h40);
        out_rdy_i = 1'b0;
        goto(2040);
        for (int c = 0; c < 200; c++) begin
            step();
            out_rdy_i = ~out_rdy_i;
            @(negedge clk);
            if (out_vld_o && out_rdy_i) got.push_back(out_data_o);
        end
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            chk($sformatf("drain_beat%0d", i), g, 8'h40 + 8'(i));
        end
        chk("drain_req_idle", cq_req_o, 1'b0);
        chk("drain_reads", qm_rd[0], 16);
        chk("drain_late_ok", drain_late_o, 1'b0);

        // Drain queue still busy at next boundary
        do_reset();
        out_rdy_i = 1'b0;
        goto(100);
        send_frame(4, 8'hA0);
        goto(2047);
        step();
        goto(2046);
        @(negedge clk);
        chk("late_pre", drain_late_o, 1'b0);
        chk("skid_full", out_vld_o, 1'b1);
        goto(0);
        @(negedge clk);
        chk("late_set", drain_late_o, 1'b1);
        chk("late_sel", fifo_sel_o, 1'b0);
        goto(300);
        @(negedge clk);
        chk("late_sticky", drain_late_o, 1'b1);
        goto(2047);
        step();

        // Reset in the middle of a frame
        goto(490);
        in_vld_i = 1'b1; in_eop_i = 1'b0; in_data_i = 8'h11;
        goto(500);
        @(negedge clk);
        chk("pre_rst", {cq_vld_o, fifo_sel_o, out_vld_o, drain_late_o}, 4'hF);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid_rst");
        step();
        @(negedge clk);
        chk("restart_pass", cq_vld_o, 1'b1);
        in_vld_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
